// File: rtl/rgb_fade_pwm.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : rgb_fade_pwm                                                   |
// | Purpose  : Turns three on/off LED requests into soft-fading PWM outputs.  |
// |            Each request is synchronised and sets a brightness target of    |
// |            0 or P_MAX_LEVEL. A per-channel level steps by one toward its   |
// |            target once every P_FADE_PERIODS PWM periods. A shared         |
// |            free-running PWM counter compares against each channel duty.   |
// | Ports    : i_clk            system clock                                  |
// |            i_rst_n          asynchronous active-low reset                 |
// |            i_led_r/g/b      on/off requests (asynchronous to i_clk)       |
// |            o_led_r/g/b      registered PWM outputs                        |
// |            o_settled        registered, high when every level == target   |
// | Options  : RGB_FADE_PWM_GAMMA_EN defined -> duty = (level*level) >> N      |
// |            (perceptual fade); undefined -> duty = level (linear).         |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module rgb_fade_pwm #(
  parameter int P_PWM_BITS     = 8,
  parameter int P_MAX_LEVEL    = 255,
  parameter int P_FADE_PERIODS = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_led_r,
  input  logic i_led_g,
  input  logic i_led_b,
  output logic o_led_r,
  output logic o_led_g,
  output logic o_led_b,
  output logic o_settled
);

  // A single fade period needs no counter bits, but keep one so the
  // register is always legal; it simply stays at zero.
  localparam int                    c_PER_W     = (P_FADE_PERIODS > 1) ? $clog2(P_FADE_PERIODS) : 1;
  localparam logic [P_PWM_BITS-1:0] c_MAX_LEVEL = P_PWM_BITS'(P_MAX_LEVEL);
  localparam logic [c_PER_W-1:0]    c_PER_LAST  = c_PER_W'(P_FADE_PERIODS - 1);

  logic [P_PWM_BITS-1:0] r_pwm_cnt;
  logic [c_PER_W-1:0]    r_per_cnt;
  logic                  w_pwm_wrap;
  logic                  w_tick;

  logic [2:0] w_led_in;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_match;
  logic [2:0] w_led_pwm;
  logic       r_settled;

  assign w_led_in = {i_led_b, i_led_g, i_led_r};

  // Last cycle of a PWM period; levels only move here so every period
  // shows one complete pulse of a single width.
  assign w_pwm_wrap = &r_pwm_cnt;
  assign w_tick     = w_pwm_wrap && (r_per_cnt == c_PER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_cnt <= '0;
      r_per_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_pwm_wrap) begin
        if (r_per_cnt == c_PER_LAST) begin
          r_per_cnt <= '0;
        end else begin
          r_per_cnt <= r_per_cnt + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronisers for the asynchronous requests.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_led_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [P_PWM_BITS-1:0] w_target;
      logic [P_PWM_BITS-1:0] r_level;
      logic [P_PWM_BITS-1:0] w_duty;
      logic                  r_led;

      assign w_target = r_sync2[gi] ? c_MAX_LEVEL : '0;

      // Unit steps toward a target in [0, P_MAX_LEVEL] can neither
      // overshoot nor wrap; a reversal just flips the step direction.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_level <= '0;
        end else if (w_tick) begin
          if (r_level < w_target) begin
            r_level <= r_level + 1'b1;
          end else if (r_level > w_target) begin
            r_level <= r_level - 1'b1;
          end
        end
      end

`ifdef RGB_FADE_PWM_GAMMA_EN
      // Square law: keep the top N bits of the 2N-bit product.
      logic [2*P_PWM_BITS-1:0] w_lvl_ext;
      logic [2*P_PWM_BITS-1:0] w_sq;
      assign w_lvl_ext = {{P_PWM_BITS{1'b0}}, r_level};
      assign w_sq      = w_lvl_ext * w_lvl_ext;
      assign w_duty    = P_PWM_BITS'(w_sq >> P_PWM_BITS);
`else
      assign w_duty = r_level;
`endif

      // High for pwm_cnt 0..duty-1, so the pulse always starts at the
      // period boundary and duty 0 never produces a pulse.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_led <= 1'b0;
        end else begin
          r_led <= (w_duty > r_pwm_cnt);
        end
      end

      assign w_match[gi]   = (r_level == w_target);
      assign w_led_pwm[gi] = r_led;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settled <= 1'b0;
    end else begin
      r_settled <= &w_match;
    end
  end

  assign o_led_r   = w_led_pwm[0];
  assign o_led_g   = w_led_pwm[1];
  assign o_led_b   = w_led_pwm[2];
  assign o_settled = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_pwm.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_rgb_fade_pwm                                                |
// | Purpose  : Self-checking bench for rgb_fade_pwm (N=4, max 15, 2 periods   |
// |            per fade step). A time-based reference model predicts every    |
// |            output; scenario tasks add spec-level pulse/timing checks.     |
// | Options  : RGB_FADE_PWM_GAMMA_EN selects the square-law duty in the model.|
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module tb_rgb_fade_pwm;

  localparam int PB   = 4;
  localparam int MAXL = 15;
  localparam int FP   = 2;
  localparam int PER  = 1 << PB;      // clocks per PWM period
  localparam int STEP = PER * FP;     // clocks per fade step

  logic clk;
  logic rst_n;
  logic in_r, in_g, in_b;
  wire  o_led_r, o_led_g, o_led_b, o_settled;

  int total = 0;
  int bad   = 0;

  rgb_fade_pwm #(
    .P_PWM_BITS     (PB),
    .P_MAX_LEVEL    (MAXL),
    .P_FADE_PERIODS (FP)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_led_r   (in_r),
    .i_led_g   (in_g),
    .i_led_b   (in_b),
    .o_led_r   (o_led_r),
    .o_led_g   (o_led_g),
    .o_led_b   (o_led_b),
    .o_settled (o_settled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Time is counted in clock edges since reset release: the PWM phase is
  // that count mod 16, a fade step happens at the last clock of every
  // 32-clock window, and a request becomes visible two edges after it is
  // sampled (kept as a short history queue per channel).
  int  m_k;
  int  m_lvl [3];
  bit  m_led [3];
  bit  m_set;
  bit  m_q   [3][$];
  int  m_pwm;
  bit  m_tick;
  bit  m_all;
  int  m_tgt;
  bit  m_in  [3];

  function automatic int f_duty(input int l);
`ifdef RGB_FADE_PWM_GAMMA_EN
    return (l * l) / PER;
`else
    return l;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   = 0;
      m_set = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_lvl[c] = 0;
        m_led[c] = 1'b0;
        m_q[c].delete();
        m_q[c].push_back(1'b0);
        m_q[c].push_back(1'b0);
      end
    end else begin
      m_in[0] = in_r;
      m_in[1] = in_g;
      m_in[2] = in_b;
      m_pwm   = m_k % PER;
      m_tick  = ((m_k % STEP) == STEP - 1);
      m_all   = 1'b1;
      for (int c = 0; c < 3; c++) begin
        m_tgt    = m_q[c][0] ? MAXL : 0;
        m_led[c] = (f_duty(m_lvl[c]) > m_pwm);
        if (m_lvl[c] != m_tgt) m_all = 1'b0;
        if (m_tick) begin
          if (m_lvl[c] < m_tgt)      m_lvl[c] = m_lvl[c] + 1;
          else if (m_lvl[c] > m_tgt) m_lvl[c] = m_lvl[c] - 1;
        end
        void'(m_q[c].pop_front());
        m_q[c].push_back(m_in[c]);
      end
      m_set = m_all;
      m_k   = m_k + 1;
    end
  end

  function automatic logic [3:0] f_exp();
    return {m_led[0], m_led[1], m_led[2], m_set};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_r  = 1'b1;
    in_g  = 1'b1;
    in_b  = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({o_led_r, o_led_g, o_led_b, o_settled} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold: rgb_settled=%b required 0000", {o_led_r, o_led_g, o_led_b, o_settled});
      end
    end
    in_r  = 1'b0;
    in_g  = 1'b0;
    in_b  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({o_led_r, o_led_g, o_led_b, o_settled} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_release: rgb_settled=%b required 0001", {o_led_r, o_led_g, o_led_b, o_settled});
    end
  endtask

  task automatic test_ramp_up();
    int  t;
    int  hi;
    bit  dropped;
    in_r    = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_settled === 1'b0) dropped = 1'b1;
    end
    total++;
    if (!dropped) begin
      bad++;
      $display("FAIL ramp_settled_drop: o_settled=%b after 3 clocks, required 0", o_settled);
    end
    t = 3;
    while (o_settled !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
      total++;
      if ({o_led_r, o_led_g, o_led_b, o_settled} !== f_exp()) begin
        bad++;
        $display("FAIL ramp_cycle t=%0d: rgb_settled=%b required %b", t, {o_led_r, o_led_g, o_led_b, o_settled}, f_exp());
      end
    end
    total++;
    if (t < 448 || t > 512) begin
      bad++;
      $display("FAIL ramp_duration: settled again after %0d clocks, required 448..512", t);
    end
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (o_led_r === 1'b1) hi++;
    end
    total++;
    if (hi != f_duty(MAXL)) begin
      bad++;
      $display("FAIL ramp_full_duty: o_led_r high %0d of 16, required %0d", hi, f_duty(MAXL));
    end
    total++;
    if (o_settled !== 1'b1) begin
      bad++;
      $display("FAIL ramp_settled_end: o_settled=%b required 1", o_settled);
    end
  endtask

  task automatic test_reversal();
    int t;
    int hi;
    int want;
    in_g = 1'b1;
    t    = 0;
    while (m_lvl[1] != 7 && t < 400) begin
      @(negedge clk);
      t++;
      total++;
      if ({o_led_r, o_led_g, o_led_b, o_settled} !== f_exp()) begin
        bad++;
        $display("FAIL rev_up_cycle t=%0d: rgb_settled=%b required %b", t, {o_led_r, o_led_g, o_led_b, o_settled}, f_exp());
      end
    end
    total++;
    if (m_lvl[1] != 7) begin
      bad++;
      $display("FAIL rev_reach7: level_g not 7 within 400 clocks (model at %0d)", m_lvl[1]);
    end
    // This negedge directly follows a fade step, so the next 16 samples
    // are one whole PWM period. Levels then walk 7,7,6,6,...,1,1,0,0.
    in_g = 1'b0;
    for (int p = 0; p < 18; p++) begin
      hi   = 0;
      want = (p < 16) ? f_duty(7 - p / 2) : 0;
      for (int i = 0; i < PER; i++) begin
        @(negedge clk);
        if (o_led_g === 1'b1) hi++;
      end
      total++;
      if (hi != want) begin
        bad++;
        $display("FAIL rev_period p=%0d: o_led_g high %0d of 16, required %0d", p, hi, want);
      end
    end
    total++;
    if (o_settled !== 1'b1) begin
      bad++;
      $display("FAIL rev_settled: o_settled=%b required 1", o_settled);
    end
  endtask

  task automatic test_glitch_free();
    logic [PER-1:0] s [3];
    logic [PER-1:0] want;
    int             d;
    int             chg;
    int             guard;
    guard = 0;
    while ((m_k % PER) != 0 && guard < PER) begin
      @(negedge clk);
      guard++;
    end
    for (int p = 0; p < 40; p++) begin
      chg = (p % 3 == 0) ? int'($urandom_range(0, PER - 1)) : -1;
      for (int i = 0; i < PER; i++) begin
        if (i == chg) begin
          in_r = 1'($urandom_range(0, 1));
          in_g = 1'($urandom_range(0, 1));
          in_b = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        s[0][i] = o_led_r;
        s[1][i] = o_led_g;
        s[2][i] = o_led_b;
        total++;
        if ({o_led_r, o_led_g, o_led_b, o_settled} !== f_exp()) begin
          bad++;
          $display("FAIL rand_cycle p=%0d i=%0d: rgb_settled=%b required %b", p, i, {o_led_r, o_led_g, o_led_b, o_settled}, f_exp());
        end
      end
      // One contiguous pulse per period, starting at its first clock.
      for (int c = 0; c < 3; c++) begin
        d = $countones(s[c]);
        want = '0;
        for (int i = 0; i < d; i++) want[i] = 1'b1;
        total++;
        if (s[c] !== want) begin
          bad++;
          $display("FAIL pulse_shape p=%0d ch=%0d: samples=%b required %b", p, c, s[c], want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int t;
    in_b = (m_lvl[2] < 9) ? 1'b1 : 1'b0;
    t    = 0;
    while (!(m_lvl[2] == 9 && m_led[2]) && t < 1000) begin
      @(negedge clk);
      t++;
      total++;
      if ({o_led_r, o_led_g, o_led_b, o_settled} !== f_exp()) begin
        bad++;
        $display("FAIL ares_cycle t=%0d: rgb_settled=%b required %b", t, {o_led_r, o_led_g, o_led_b, o_settled}, f_exp());
      end
    end
    total++;
    if (!(m_lvl[2] == 9 && o_led_b === 1'b1)) begin
      bad++;
      $display("FAIL ares_reach9: o_led_b=%b model level %0d, required level 9 with output high", o_led_b, m_lvl[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_led_r, o_led_g, o_led_b, o_settled} !== 4'b0000) begin
      bad++;
      $display("FAIL ares_immediate: rgb_settled=%b required 0000 without a clock", {o_led_r, o_led_g, o_led_b, o_settled});
    end
    in_b = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Level restarts at 0: dark until the first fade step at clock 32.
    for (int i = 1; i <= STEP + 1; i++) begin
      @(negedge clk);
      total++;
      if (o_led_b !== ((i == STEP + 1) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL ares_restart i=%0d: o_led_b=%b required %b", i, o_led_b, (i == STEP + 1));
      end
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      total++;
      if ({o_led_r, o_led_g, o_led_b, o_settled} !== f_exp()) begin
        bad++;
        $display("FAIL ares_after i=%0d: rgb_settled=%b required %b", i, {o_led_r, o_led_g, o_led_b, o_settled}, f_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_glitch_free();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
